// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set 2 scan-code decoder.
// Turns the receiver's byte stream into key events {code, extended, break}
// by folding the E0 / F0 / E1 prefixes, then queues the events in a small
// FIFO that the key-processing logic drains with ev_pop.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int CNT_W          = 22
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         ev_pop,
  output logic                         ev_valid,
  output logic [7:0]                   ev_code,
  output logic                         ev_ext,
  output logic                         ev_break,
  output logic [$clog2(FIFO_DEPTH):0]  ev_count,
  output logic                         overflow,
  output logic                         err_pulse
);

  localparam int                AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GOT_E0     = 3'd1,
    ST_GOT_F0     = 3'd2,
    ST_GOT_E0F0   = 3'd3,
    ST_SKIP_PAUSE = 3'd4
  } state_t;

  // Bytes the keyboard sends as command replies, never as key data.
  function automatic logic is_ctrl_response(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // Bytes that can never follow a break prefix.
  function automatic logic is_bad_after_f0(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
  endfunction

  state_t            state_r, state_nxt_s;
  logic [2:0]        skip_r, skip_nxt_s;
  logic [CNT_W-1:0]  tmo_cnt_r;
  logic              tmo_hit_s;
  logic              push_s;
  logic [9:0]        push_ev_s;   // {code, ext, brk}
  logic              err_s;
  logic              err_pulse_r;

  logic [9:0]        mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [AW:0]       count_r;
  logic              overflow_r;
  logic              pop_s, full_s, wr_en_s;
  logic [9:0]        head_s;

  // A timeout fires only while inside a sequence and only when no byte competes.
  assign tmo_hit_s = !rx_valid && (state_r != ST_IDLE) && (tmo_cnt_r == TMO_LAST);

  // Next-state, event and error decode for the prefix FSM.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_r;
    push_s      = 1'b0;
    push_ev_s   = 10'h000;
    err_s       = 1'b0;
    if (rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_data == 8'hE0) begin
            state_nxt_s = ST_GOT_E0;
          end else if (rx_data == 8'hF0) begin
            state_nxt_s = ST_GOT_F0;
          end else if (rx_data == 8'hE1) begin
            state_nxt_s = ST_SKIP_PAUSE;
            skip_nxt_s  = 3'd7;
          end else if (rx_data == 8'h00) begin
            err_s = 1'b1;
          end else if (is_ctrl_response(rx_data)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            push_s    = 1'b1;
            push_ev_s = {rx_data, 1'b0, 1'b0};
          end
        end
        ST_GOT_E0: begin
          state_nxt_s = ST_IDLE;
          if (rx_data == 8'hF0) begin
            state_nxt_s = ST_GOT_E0F0;
          end else if (rx_data == 8'hE0) begin
            state_nxt_s = ST_GOT_E0;
          end else if (rx_data == 8'h12) begin
            state_nxt_s = ST_IDLE;        // fake shift
          end else if ((rx_data == 8'h00) || (rx_data == 8'hE1)) begin
            err_s = 1'b1;
          end else begin
            push_s    = 1'b1;
            push_ev_s = {rx_data, 1'b1, 1'b0};
          end
        end
        ST_GOT_F0: begin
          state_nxt_s = ST_IDLE;
          if (is_bad_after_f0(rx_data)) begin
            err_s = 1'b1;
          end else begin
            push_s    = 1'b1;
            push_ev_s = {rx_data, 1'b0, 1'b1};
          end
        end
        ST_GOT_E0F0: begin
          state_nxt_s = ST_IDLE;
          if (rx_data == 8'h12) begin
            state_nxt_s = ST_IDLE;        // fake shift release
          end else if (is_bad_after_f0(rx_data)) begin
            err_s = 1'b1;
          end else begin
            push_s    = 1'b1;
            push_ev_s = {rx_data, 1'b1, 1'b1};
          end
        end
        ST_SKIP_PAUSE: begin
          skip_nxt_s = skip_r - 3'd1;
          if (skip_r == 3'd1) begin
            state_nxt_s = ST_IDLE;
            push_s      = 1'b1;
            push_ev_s   = {8'hE1, 1'b0, 1'b0};
          end else begin
            state_nxt_s = ST_SKIP_PAUSE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else if (tmo_hit_s) begin
      state_nxt_s = ST_IDLE;
      err_s       = 1'b1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state, pause-skip counter and registered error strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      skip_r      <= 3'd0;
      err_pulse_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      skip_r      <= skip_nxt_s;
      err_pulse_r <= err_s;
    end
  end

  // Inter-byte idle counter; only runs while a sequence is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (rx_valid || (state_r == ST_IDLE) || tmo_hit_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end
  end

  // A pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
  assign pop_s   = ev_pop && (count_r != '0);
  assign full_s  = (count_r == FULL_CNT);
  assign wr_en_s = push_s && (!full_s || pop_s);

  // Event storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 10'h000;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_ev_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (push_s && !wr_en_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign head_s    = mem_r[rd_ptr_r];
  assign ev_valid  = (count_r != '0);
  assign ev_code   = ev_valid ? head_s[9:2] : 8'h00;
  assign ev_ext    = ev_valid ? head_s[1]   : 1'b0;
  assign ev_break  = ev_valid ? head_s[0]   : 1'b0;
  assign ev_count  = count_r;
  assign overflow  = overflow_r;
  assign err_pulse = err_pulse_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed testbench for ps2_scancode_decoder (FIFO_DEPTH=4, TIMEOUT_CYCLES=100).
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ev_pop = 1'b0;
  logic       ev_valid, ev_ext, ev_break, overflow, err_pulse;
  logic [7:0] ev_code;
  logic [2:0] ev_count;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int err_base;
  int first;

  ps2_scancode_decoder #(
    .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100), .CNT_W(22)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .ev_pop(ev_pop), .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_count(ev_count), .overflow(overflow),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // Count cycles with err_pulse high, sampled mid-cycle.
  always @(negedge clk) begin
    if (err_pulse) err_cnt <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    check_eq(tag, 32'({ev_valid, ev_code, ev_ext, ev_break}), 32'({1'b1, code, ext, brk}));
  endtask

  // One-cycle strobe; returns at the negedge right after the sampling edge.
  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    strobe(b);
    repeat (gap) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    ev_pop = 1'b1;
    @(negedge clk);
    ev_pop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check_eq("rst_valid",    32'(ev_valid),  32'd0);
    check_eq("rst_count",    32'(ev_count),  32'd0);
    check_eq("rst_overflow", 32'(overflow),  32'd0);
    check_eq("rst_err",      32'(err_pulse), 32'd0);
    check_eq("rst_head",     32'({ev_code, ev_ext, ev_break}), 32'd0);

    // Make then break of the same key.
    err_base = err_cnt;
    send(8'h1C, 10);
    send(8'hF0, 10);
    send(8'h1C, 10);
    check_eq("mb_count", 32'(ev_count), 32'd2);
    expect_head("mb_make", 8'h1C, 1'b0, 1'b0);
    pop_one();
    expect_head("mb_break", 8'h1C, 1'b0, 1'b1);
    pop_one();
    check_eq("mb_empty", 32'(ev_valid), 32'd0);
    check_eq("mb_noerr", 32'(err_cnt - err_base), 32'd0);

    // Extended break, then extended make preceded by fake shift.
    send(8'hE0, 2); send(8'hF0, 2); send(8'h75, 2);
    check_eq("e0f0_count", 32'(ev_count), 32'd1);
    expect_head("e0f0_head", 8'h75, 1'b1, 1'b1);
    pop_one();
    send(8'hE0, 2); send(8'h12, 2); send(8'hE0, 2); send(8'h70, 2);
    check_eq("fake_count", 32'(ev_count), 32'd1);
    expect_head("fake_head", 8'h70, 1'b1, 1'b0);
    pop_one();

    // Pause sequence collapses to one event; controller replies vanish.
    send(8'hE1, 1); send(8'h14, 1); send(8'h77, 1); send(8'hE1, 1);
    send(8'hF0, 1); send(8'h14, 1); send(8'hF0, 1);
    check_eq("pause_partial", 32'(ev_count), 32'd0);
    send(8'h77, 1);
    check_eq("pause_count", 32'(ev_count), 32'd1);
    expect_head("pause_head", 8'hE1, 1'b0, 1'b0);
    pop_one();
    send(8'hFA, 1); send(8'hAA, 1);
    check_eq("resp_count", 32'(ev_count), 32'd0);
    check_eq("seq_noerr", 32'(err_cnt - err_base), 32'd0);

    // Timeout after a lone F0.
    err_base = err_cnt;
    first = -1;
    strobe(8'hF0);
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (err_pulse && first < 0) first = k;
    end
    check_eq("tmo_latency", 32'(first), 32'd100);
    check_eq("tmo_one_pulse", 32'(err_cnt - err_base), 32'd1);
    send(8'h1C, 1);
    expect_head("tmo_idle_after", 8'h1C, 1'b0, 1'b0);
    pop_one();

    // Overflow on the fifth push.
    send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0); send(8'h2D, 0); send(8'h2C, 1);
    check_eq("ovf_count", 32'(ev_count), 32'd4);
    check_eq("ovf_flag",  32'(overflow), 32'd1);
    expect_head("ovf_h0", 8'h15, 1'b0, 1'b0);
    pop_one();
    expect_head("ovf_h1", 8'h1D, 1'b0, 1'b0);
    pop_one();
    expect_head("ovf_h2", 8'h24, 1'b0, 1'b0);
    pop_one();
    expect_head("ovf_h3", 8'h2D, 1'b0, 1'b0);
    pop_one();
    check_eq("ovf_drained", 32'(ev_valid), 32'd0);
    check_eq("ovf_sticky",  32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    check_eq("rst_clears_ovf", 32'(overflow), 32'd0);
    send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0); send(8'h2D, 0);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h2C; ev_pop = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00; ev_pop = 1'b0;
    check_eq("pp_count", 32'(ev_count), 32'd4);
    check_eq("pp_noovf", 32'(overflow), 32'd0);
    expect_head("pp_h0", 8'h1D, 1'b0, 1'b0);
    pop_one(); pop_one(); pop_one();
    expect_head("pp_h3", 8'h2C, 1'b0, 1'b0);
    pop_one();
    pop_one();
    check_eq("pop_empty_ignored", 32'(ev_count), 32'd0);

    // Push and pop while empty: the push lands.
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h3C; ev_pop = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00; ev_pop = 1'b0;
    check_eq("pp_empty_count", 32'(ev_count), 32'd1);
    expect_head("pp_empty_head", 8'h3C, 1'b0, 1'b0);
    pop_one();

    // Illegal byte after F0.
    err_base = err_cnt;
    send(8'hF0, 1); send(8'h00, 3);
    check_eq("f0_00_err", 32'(err_cnt - err_base), 32'd1);
    check_eq("f0_00_noev", 32'(ev_count), 32'd0);

    // Reset in the middle of an E0 sequence.
    err_base = err_cnt;
    send(8'hE0, 1);
    do_reset();
    send(8'h70, 1);
    expect_head("rst_mid_head", 8'h70, 1'b0, 1'b0);
    check_eq("rst_mid_noerr", 32'(err_cnt - err_base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
